aibcr3aux_osc_seq_ctrl: RTL and testbench
=========================================

AIBCR3AUX_OSC_SEQ_CTRL -- requirements
Module: aibcr3aux_osc_seq_ctrl

Interface
REQ-001 SHALL have port clkin  input  1  aux controller clock, all state on rising edge.
REQ-002 SHALL have port irst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port osc_en  input  1  level request to start and keep the aux oscillator divider running.
REQ-004 SHALL have port settle_cyc  input  8  oscillator settle wait, in clkin cycles; sampled on IDLE->SETTLE.
REQ-005 SHALL have port timeout_cyc  input  8  max wait for divider sync-reset release; sampled on SETTLE->RELEASE.
REQ-006 SHALL have port syncrstb_in  input  1  sync-reset-release from the divider, asynchronous to clkin.
REQ-007 SHALL have port scan_mode_n  input  1  0 = scan mode.
REQ-008 SHALL have port osc_irstb  output  1  active-low reset to the divider (its irstb).
REQ-009 SHALL have port osc_ready  output  1  divider running and released.
REQ-010 SHALL have port osc_err  output  1  sequencing fault, held until osc_en deasserts.
REQ-011 SHALL have port seq_state  output  3  current FSM state encoding.

Function
REQ-012 SHALL resynchronise syncrstb_in through a 2-flop synchroniser (reset 0); "sync" below means its output.
REQ-013 SHALL implement FSM states IDLE=0, SETTLE=1, RELEASE=2, RUN=3, ERR=4; encodings 5-7 SHALL go to IDLE next cycle.
REQ-014 IDLE: osc_en=1 -> SETTLE; 8-bit down-counter loaded with settle_cyc.
REQ-015 SETTLE: counter decrements each cycle; counter==0 -> RELEASE; counter loaded with timeout_cyc; settle_cyc=0 gives exactly one SETTLE cycle.
REQ-016 RELEASE: sync=1 -> RUN (priority over timeout); else counter==0 -> ERR; else decrement.
REQ-017 RUN: sync=0 -> ERR (divider lost release).
REQ-018 ERR: held while osc_en=1; no self-recovery.
REQ-019 osc_en=0 in any state -> IDLE next cycle; this SHALL take priority over every other transition.
REQ-020 Outputs registered and decoded from state: osc_irstb=1 in RELEASE and RUN only; osc_ready=1 in RUN only; osc_err=1 in ERR only.
REQ-021 seq_state SHALL equal the state register.
REQ-022 Latency: syncrstb_in rising at cycle t in RELEASE -> state RUN at cycle t+3 (osc_ready high from t+3).
REQ-023 scan_mode_n=0: FSM SHALL be held in IDLE; counter SHALL be cleared; osc_irstb SHALL be forced to 1 combinationally; osc_ready=0, osc_err=0.
REQ-024 scan_mode_n returning to 1: normal sequencing SHALL restart from IDLE.
REQ-025 The counter SHALL never wrap; decrement only when nonzero.

Reset
REQ-026 irst=1 SHALL asynchronously force state IDLE, counter 0, synchroniser flops 0.
REQ-027 irst=1 SHALL asynchronously force osc_irstb=0 (scan_mode_n=1), osc_ready=0, osc_err=0, seq_state=0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately.
REQ-029 After irst deasserts with osc_en=1, the full sequence SHALL restart from SETTLE on the first edge.

Verification
REQ-030 Nominal start: settle_cyc=4, timeout_cyc=10, osc_en=1 at cycle 0, syncrstb_in=1 at cycle 8 -> SETTLE cycles 1-5; osc_irstb=1 from cycle 6; osc_ready=1 at cycle 11.
REQ-031 Timeout: timeout_cyc=3, syncrstb_in held 0 -> ERR 4 cycles after RELEASE entry; osc_err=1 and osc_irstb=0; both persist until osc_en=0; then IDLE next cycle.
REQ-032 Loss in RUN: syncrstb_in dropped to 0 in RUN -> ERR exactly 3 cycles later; osc_ready=0.
REQ-033 Boundaries, case 1: settle_cyc=0 -> one SETTLE cycle.
REQ-034 Boundaries, case 2: timeout_cyc=0 with sync=1 already on RELEASE entry -> RUN, not ERR.
REQ-035 Boundaries, case 3: osc_en=0 in the same cycle as a timeout -> IDLE.
REQ-036 Reset/scan: irst pulse mid-RELEASE -> all outputs 0 asynchronously.
REQ-037 Reset/scan: scan_mode_n=0 in RUN -> osc_irstb=1 immediately, state IDLE next edge, osc_ready=0.

Source files
------------

// File: rtl/aibcr3aux_osc_seq_ctrl_if.sv
// rtl/aibcr3aux_osc_seq_ctrl_if.sv - control/status bundle between aux controller and oscillator sequencer
interface aibcr3aux_osc_seq_ctrl_if;
    logic       osc_en;
    logic [7:0] settle_cyc;
    logic [7:0] timeout_cyc;
    logic       syncrstb_in;
    logic       scan_mode_n;
    logic       osc_irstb;
    logic       osc_ready;
    logic       osc_err;
    logic [2:0] seq_state;

    modport slave (
        input  osc_en, settle_cyc, timeout_cyc, syncrstb_in, scan_mode_n,
        output osc_irstb, osc_ready, osc_err, seq_state
    );

    modport master (
        output osc_en, settle_cyc, timeout_cyc, syncrstb_in, scan_mode_n,
        input  osc_irstb, osc_ready, osc_err, seq_state
    );
endinterface

// File: rtl/aibcr3aux_osc_seq_ctrl.sv
// rtl/aibcr3aux_osc_seq_ctrl.sv - aux oscillator divider start/settle/release sequencer
module aibcr3aux_osc_seq_ctrl (
    input  logic                         clkin,
    input  logic                         irst,
    aibcr3aux_osc_seq_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       sync_meta;
    logic       sync_q;
    logic       irstb_q;
    logic       ready_q;
    logic       err_q;

    // Two-flop resync of the divider's release flag into the clkin domain
    always_ff @(posedge clkin or posedge irst) begin
        if (irst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= bus.syncrstb_in;
            sync_q    <= sync_meta;
        end
    end

    // State, counter and output registers; outputs decoded from the next state so they align with seq_state
    always_ff @(posedge clkin or posedge irst) begin
        if (irst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            irstb_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irstb_q <= (state_d == ST_RELEASE) || (state_d == ST_RUN);
            ready_q <= (state_d == ST_RUN);
            err_q   <= (state_d == ST_ERR);
        end
    end

    // Next-state and counter logic; scan and osc_en drop override every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.scan_mode_n || !bus.osc_en) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = bus.settle_cyc;
                end
                ST_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_RELEASE;
                        cnt_d   = bus.timeout_cyc;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (sync_q) begin
                        state_d = ST_RUN;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == 8'd0) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (!sync_q) begin
                        state_d = ST_ERR;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Scan forces the divider out of reset and masks status without waiting for a clock
    assign bus.osc_irstb = irstb_q | ~bus.scan_mode_n;
    assign bus.osc_ready = ready_q & bus.scan_mode_n;
    assign bus.osc_err   = err_q & bus.scan_mode_n;
    assign bus.seq_state = state_q;

endmodule

// File: tb/tb_aibcr3aux_osc_seq_ctrl.sv
// tb/tb_aibcr3aux_osc_seq_ctrl.sv - self-checking bench for the aux oscillator sequencer
module tb_aibcr3aux_osc_seq_ctrl;

    localparam int NEVER = 1 << 30;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aibcr3aux_osc_seq_ctrl_if bus ();

    aibcr3aux_osc_seq_ctrl dut (
        .clkin (clk),
        .irst  (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int es);
        check({tag, "_state"}, {29'd0, bus.seq_state}, es);
        check({tag, "_irstb"}, {31'd0, bus.osc_irstb}, (es == 2 || es == 3) ? 1 : 0);
        check({tag, "_ready"}, {31'd0, bus.osc_ready}, (es == 3) ? 1 : 0);
        check({tag, "_err"},   {31'd0, bus.osc_err},   (es == 4) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE with the synchroniser flushed, then raise osc_en: the current cycle is cycle 0
    task automatic start_seq(input int s, input int tmo);
        bus.osc_en      = 1'b0;
        bus.syncrstb_in = 1'b0;
        repeat (4) step();
        bus.settle_cyc  = s[7:0];
        bus.timeout_cyc = tmo[7:0];
        bus.osc_en      = 1'b1;
    endtask

    // Expected timeline from arithmetic: SETTLE lasts s+1 cycles, release seen 2 cycles after the input rises
    task automatic run_trial(input int s, input int tmo, input int t_sync, input bit drop, input int drop_dly);
        int  r, obs, run_c, err_c, u, last, es;
        bit  has_run;
        r   = s + 2;
        obs = (t_sync + 2 > r) ? t_sync + 2 : r;
        if (obs <= r + tmo) begin
            has_run = 1'b1;
            run_c   = obs + 1;
            u       = drop ? run_c + drop_dly : NEVER;
            err_c   = drop ? u + 3 : NEVER;
            last    = drop ? err_c + 3 : run_c + 4;
        end else begin
            has_run = 1'b0;
            run_c   = NEVER;
            u       = NEVER;
            err_c   = r + tmo + 1;
            last    = err_c + 3;
        end
        start_seq(s, tmo);
        for (int k = 0; k <= last; k++) begin
            bus.syncrstb_in = (k >= t_sync) && (k < u);
            if (k >= 1) bus.settle_cyc = 8'($urandom);
            if (k >= r) bus.timeout_cyc = 8'($urandom);
            if (k == 0)               es = 0;
            else if (k < r)           es = 1;
            else if (has_run) es = (k < run_c) ? 2 : ((k < err_c) ? 3 : 4);
            else              es = (k < err_c) ? 2 : 4;
            @(negedge clk);
            check_all($sformatf("trial_s%0d_t%0d_k%0d", s, tmo, k), es);
            step();
        end
        bus.osc_en = 1'b0;
        step();
        check_all($sformatf("trial_s%0d_t%0d_exit", s, tmo), 0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.osc_en      = 1'b0;
        bus.settle_cyc  = 8'd0;
        bus.timeout_cyc = 8'd0;
        bus.syncrstb_in = 1'b0;
        bus.scan_mode_n = 1'b1;
        #1;
        check_all("reset_async", 0);
        repeat (2) step();
        check_all("reset_held", 0);
        rst = 1'b0;
        step();
        check_all("post_reset_idle", 0);

        // Nominal start, timeout, loss in RUN, settle 0, timeout 0 with release already present
        run_trial(4, 10, 8, 1'b0, 0);
        run_trial(2, 3, 1000, 1'b0, 0);
        run_trial(3, 5, 2, 1'b1, 2);
        run_trial(0, 4, 2, 1'b0, 0);
        run_trial(0, 0, 0, 1'b0, 0);

        // osc_en drops in the very cycle the release timeout expires
        start_seq(1, 2);
        repeat (5) step();
        check("en_drop_at_timeout_pre", {29'd0, bus.seq_state}, 2);
        bus.osc_en = 1'b0;
        step();
        check_all("en_drop_at_timeout", 0);

        // Reset mid-RELEASE aborts asynchronously, then restarts from SETTLE
        start_seq(0, 20);
        repeat (4) step();
        check("rst_mid_pre_irstb", {31'd0, bus.osc_irstb}, 1);
        #2 rst = 1'b1;
        #1;
        check_all("rst_mid_release", 0);
        step();
        rst = 1'b0;
        step();
        check_all("restart_after_rst", 1);

        // Scan entry in RUN, hold in IDLE, resume on exit
        start_seq(0, 5);
        bus.syncrstb_in = 1'b1;
        repeat (4) step();
        check_all("scan_pre_run", 3);
        #2 bus.scan_mode_n = 1'b0;
        #1;
        check("scan_irstb_comb", {31'd0, bus.osc_irstb}, 1);
        check("scan_ready_comb", {31'd0, bus.osc_ready}, 0);
        step();
        check("scan_state_idle", {29'd0, bus.seq_state}, 0);
        check("scan_irstb", {31'd0, bus.osc_irstb}, 1);
        check("scan_ready", {31'd0, bus.osc_ready}, 0);
        check("scan_err", {31'd0, bus.osc_err}, 0);
        step();
        check("scan_hold_idle", {29'd0, bus.seq_state}, 0);
        bus.scan_mode_n = 1'b1;
        #1;
        check("scan_exit_irstb", {31'd0, bus.osc_irstb}, 0);
        step();
        check_all("scan_exit_settle", 1);
        bus.osc_en = 1'b0;
        step();

        // Randomised trials against the timeline model
        for (int n = 0; n < 40; n++) begin
            int s, tmo;
            s   = $urandom_range(0, 10);
            tmo = $urandom_range(0, 10);
            run_trial(s, tmo, $urandom_range(0, s + tmo + 6), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
